// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit (lw, sw, R-type, I-ALU, beq, jal).
//
// A Moore FSM sequences each instruction through fetch, decode and the
// execute/memory/writeback states. Anything it cannot execute parks the FSM
// in a trap state with a sticky illegal flag, which only reset clears.
//
// Most outputs are registered. They are decoded from the next state, so each
// register already holds the value for the state being entered. irwrite and
// pcwrite also depend on mem_ready/zero in the current cycle, so they are
// combinational. immsrc is a pure decode of op.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   op, funct3,      instruction fields from the instruction register
//   funct7b5
//   zero             ALU result == 0
//   mem_ready        memory access completes this cycle
//   alucontrol       000 add, 001 sub, 010 and, 011 or
//   alusrca          00 PC, 01 old PC, 10 rs1
//   alusrcb          00 rs2, 01 imm, 10 constant 4
//   resultsrc        00 ALUOut, 01 read data, 10 ALU result
//   immsrc           00 I, 01 S, 10 B, 11 J
//   adrsrc, irwrite, memwrite, regwrite, pcwrite   datapath enables
//   illegal          sticky unsupported-instruction flag
module multicycle_controller #(
  parameter int unsigned XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alucontrol,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [1:0] immsrc,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       pcwrite,
  output logic       illegal
);

  // The controller never touches the datapath width; an RV32 datapath is the
  // narrowest this sequencing is meant for.
  if (XLEN < 32) begin : g_xlen_below_rv32
  end

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBeq,
    StJal,
    StTrap
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] alucontrol_q, alucontrol_d;
  logic [1:0] alusrca_q, alusrca_d;
  logic [1:0] alusrcb_q, alusrcb_d;
  logic [1:0] resultsrc_q, resultsrc_d;
  logic       adrsrc_q, adrsrc_d;
  logic       memwrite_q, memwrite_d;
  logic       regwrite_q, regwrite_d;
  logic       illegal_q, illegal_d;

  // Only add/sub, and, or are implemented for R-type and I-ALU.
  logic       alu_funct3_ok;
  logic [2:0] alu_exec;

  always_comb begin
    alu_funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110);
  end

  // ALU operation for the execute states; addi ignores funct7b5.
  always_comb begin
    alu_exec = AluAdd;
    case (funct3)
      3'b000:  alu_exec = (funct7b5 && (op == OpReg)) ? AluSub : AluAdd;
      3'b111:  alu_exec = AluAnd;
      3'b110:  alu_exec = AluOr;
      default: alu_exec = AluAdd;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (op)
          OpLoad,
          OpStore:  state_d = StMemAdr;
          OpReg:    state_d = alu_funct3_ok ? StExecR : StTrap;
          OpImm:    state_d = alu_funct3_ok ? StExecI : StTrap;
          OpBranch: state_d = (funct3 == 3'b000) ? StBeq : StTrap;
          OpJal:    state_d = StJal;
          default:  state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
      StExecR,
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  // Moore outputs for the state being entered.
  always_comb begin
    alucontrol_d = AluAdd;
    alusrca_d    = 2'b00;
    alusrcb_d    = 2'b00;
    resultsrc_d  = 2'b00;
    adrsrc_d     = 1'b0;
    memwrite_d   = 1'b0;
    regwrite_d   = 1'b0;
    unique case (state_d)
      StFetch: begin
        alusrcb_d   = 2'b10;
        resultsrc_d = 2'b10;
      end
      StDecode: begin
        alusrca_d = 2'b01;
        alusrcb_d = 2'b01;
      end
      StMemAdr: begin
        alusrca_d = 2'b10;
        alusrcb_d = 2'b01;
      end
      StMemRead: begin
        adrsrc_d = 1'b1;
      end
      StMemWb: begin
        resultsrc_d = 2'b01;
        regwrite_d  = 1'b1;
      end
      StMemWrite: begin
        adrsrc_d   = 1'b1;
        memwrite_d = 1'b1;
      end
      StExecR: begin
        alusrca_d    = 2'b10;
        alucontrol_d = alu_exec;
      end
      StExecI: begin
        alusrca_d    = 2'b10;
        alusrcb_d    = 2'b01;
        alucontrol_d = alu_exec;
      end
      StAluWb: begin
        regwrite_d = 1'b1;
      end
      StBeq: begin
        alusrca_d    = 2'b10;
        alucontrol_d = AluSub;
      end
      StJal: begin
        alusrca_d = 2'b01;
        alusrcb_d = 2'b10;
      end
      StTrap: begin
      end
      default: begin
      end
    endcase
    illegal_d = illegal_q | (state_d == StTrap);
  end

  // Reset values are the FETCH outputs with every enable off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      alucontrol_q <= AluAdd;
      alusrca_q    <= 2'b00;
      alusrcb_q    <= 2'b10;
      resultsrc_q  <= 2'b10;
      adrsrc_q     <= 1'b0;
      memwrite_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alucontrol_q <= alucontrol_d;
      alusrca_q    <= alusrca_d;
      alusrcb_q    <= alusrcb_d;
      resultsrc_q  <= resultsrc_d;
      adrsrc_q     <= adrsrc_d;
      memwrite_q   <= memwrite_d;
      regwrite_q   <= regwrite_d;
      illegal_q    <= illegal_d;
    end
  end

  always_comb begin
    immsrc = 2'b00;
    case (op)
      OpStore:  immsrc = 2'b01;
      OpBranch: immsrc = 2'b10;
      OpJal:    immsrc = 2'b11;
      default:  immsrc = 2'b00;
    endcase
  end

  // rst_n gates the input-dependent enables, which would otherwise follow
  // mem_ready while the FSM is held in FETCH by reset.
  always_comb begin
    irwrite = rst_n && (state_q == StFetch) && mem_ready;
    pcwrite = rst_n && (((state_q == StFetch) && mem_ready) ||
                        ((state_q == StBeq) && zero) ||
                        (state_q == StJal));
  end

  assign alucontrol = alucontrol_q;
  assign alusrca    = alusrca_q;
  assign alusrcb    = alusrcb_q;
  assign resultsrc  = resultsrc_q;
  assign adrsrc     = adrsrc_q;
  assign memwrite   = memwrite_q;
  assign regwrite   = regwrite_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. Each instruction is expanded into the
// list of cycles it must occupy; every cycle gets an expected output vector
// derived from the per-phase control table and is checked on the falling
// edge. A monitor also measures instruction lengths (irwrite to irwrite) and
// counts enables for literal checks.
module tb_multicycle_controller;

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpJal = 7'b1101111;
  localparam logic [6:0] OpBad = 7'b1111111;

  typedef enum int {
    PhFetch, PhDecode, PhMemAdr, PhMemRead, PhMemWb, PhMemWrite,
    PhExecR, PhExecI, PhAluWb, PhBeq, PhJal, PhTrap
  } phase_e;

  typedef struct packed {
    logic [2:0] alu;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] res;
    logic [1:0] imm;
    logic       adr;
    logic       ir;
    logic       mw;
    logic       rw;
    logic       pcw;
    logic       ill;
  } outs_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alucontrol;
  logic [1:0] alusrca, alusrcb, resultsrc, immsrc;
  logic       adrsrc, irwrite, memwrite, regwrite, pcwrite, illegal;

  multicycle_controller #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .zero      (zero),
    .mem_ready (mem_ready),
    .alucontrol(alucontrol),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .resultsrc (resultsrc),
    .immsrc    (immsrc),
    .adrsrc    (adrsrc),
    .irwrite   (irwrite),
    .memwrite  (memwrite),
    .regwrite  (regwrite),
    .pcwrite   (pcwrite),
    .illegal   (illegal)
  );

  outs_t act;
  assign act = {alucontrol, alusrca, alusrcb, resultsrc, immsrc,
                adrsrc, irwrite, memwrite, regwrite, pcwrite, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  outs_t exp_q[$];
  int    exp_len_q[$];
  int    lens_q[$];
  int    cyc = 0;
  int    last_ir = -1;
  int    mw_cnt = 0, rw_cnt = 0, pcw_cnt = 0, en_cnt = 0;
  logic [2:0] exec_alu = 3'b000;
  outs_t e_cur;

  function automatic void check(input string name, input logic [31:0] a,
                                input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, a, e);
    end
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == OpSw) return 2'b01;
    if (o == OpBeq) return 2'b10;
    if (o == OpJal) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_of();
    if (funct3 == 3'b111) return 3'b010;
    if (funct3 == 3'b110) return 3'b011;
    return (funct7b5 && op == OpR) ? 3'b001 : 3'b000;
  endfunction

  // Control values each phase must present.
  function automatic outs_t model(input phase_e ph, input logic mr);
    outs_t o;
    o = '0;
    o.imm = imm_of(op);
    case (ph)
      PhFetch:    begin o.b = 2'b10; o.res = 2'b10; o.ir = mr; o.pcw = mr; end
      PhDecode:   begin o.a = 2'b01; o.b = 2'b01; end
      PhMemAdr:   begin o.a = 2'b10; o.b = 2'b01; end
      PhMemRead:  o.adr = 1'b1;
      PhMemWb:    begin o.res = 2'b01; o.rw = 1'b1; end
      PhMemWrite: begin o.adr = 1'b1; o.mw = 1'b1; end
      PhExecR:    begin o.a = 2'b10; o.alu = alu_of(); end
      PhExecI:    begin o.a = 2'b10; o.b = 2'b01; o.alu = alu_of(); end
      PhAluWb:    o.rw = 1'b1;
      PhBeq:      begin o.a = 2'b10; o.alu = 3'b001; o.pcw = zero; end
      PhJal:      begin o.a = 2'b01; o.b = 2'b10; o.pcw = 1'b1; end
      PhTrap:     o.ill = 1'b1;
      default:    o = '0;
    endcase
    return o;
  endfunction

  // Compare process and monitor.
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      check($sformatf("outs@cyc%0d", cyc), 32'(act), 32'(e_cur));
    end
    if (!rst_n) begin
      last_ir = -1;
    end else begin
      cyc++;
      mw_cnt  += int'(memwrite);
      rw_cnt  += int'(regwrite);
      pcw_cnt += int'(pcwrite);
      en_cnt  += int'(irwrite | memwrite | regwrite | pcwrite);
      if (alusrca == 2'b10) exec_alu = alucontrol;
      if (irwrite) begin
        if (last_ir >= 0) lens_q.push_back(cyc - last_ir);
        last_ir = cyc;
      end
    end
  end

  task automatic step(input phase_e ph, input logic mr);
    mem_ready = mr;
    exp_q.push_back(model(ph, mr));
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction. fs = fetch stall cycles, ms = memory stall cycles.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int fs, input int ms);
    logic legal;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    legal = (o == OpLw) || (o == OpSw) || (o == OpJal) || (o == OpBeq && f3 == 3'b000) ||
            ((o == OpR || o == OpI) && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110));
    repeat (fs) step(PhFetch, 1'b0);
    step(PhFetch, 1'b1);
    step(PhDecode, 1'b1);
    if (!legal) begin
      repeat (20) step(PhTrap, 1'($urandom_range(1)));
    end else begin
      case (o)
        OpLw: begin
          step(PhMemAdr, 1'b1);
          repeat (ms) step(PhMemRead, 1'b0);
          step(PhMemRead, 1'b1);
          step(PhMemWb, 1'b1);
          exp_len_q.push_back(5 + ms);
        end
        OpSw: begin
          step(PhMemAdr, 1'b1);
          repeat (ms) step(PhMemWrite, 1'b0);
          step(PhMemWrite, 1'b1);
          exp_len_q.push_back(4 + ms);
        end
        OpR:   begin step(PhExecR, 1'b1); step(PhAluWb, 1'b1); exp_len_q.push_back(4); end
        OpI:   begin step(PhExecI, 1'b1); step(PhAluWb, 1'b1); exp_len_q.push_back(4); end
        OpBeq: begin step(PhBeq, 1'b1); exp_len_q.push_back(3); end
        default: begin step(PhJal, 1'b1); step(PhAluWb, 1'b1); exp_len_q.push_back(4); end
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int mw0, rw0, pcw0, en0;

  initial begin
    rst_n = 1'b1; op = OpR; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    // In reset with mem_ready high: FETCH values, enables off.
    repeat (2) begin
      exp_q.push_back(model(PhFetch, 1'b0));
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;

    rw0 = rw_cnt;
    run_instr(OpR, 3'b000, 1'b1, 1'b0, 0, 0);
    check("sub_regwrite_cycles", 32'(rw_cnt - rw0), 1);
    check("sub_alucontrol", 32'(exec_alu), 32'h1);

    run_instr(OpI, 3'b000, 1'b1, 1'b0, 0, 0);
    check("addi_ignores_f7", 32'(exec_alu), 32'h0);
    run_instr(OpI, 3'b110, 1'b0, 1'b0, 0, 0);
    check("ori_alucontrol", 32'(exec_alu), 32'h3);
    run_instr(OpR, 3'b111, 1'b1, 1'b0, 0, 0);
    check("and_alucontrol", 32'(exec_alu), 32'h2);

    rw0 = rw_cnt;
    run_instr(OpLw, 3'b010, 1'b0, 1'b0, 0, 2);
    check("lw_regwrite_cycles", 32'(rw_cnt - rw0), 1);

    mw0 = mw_cnt; rw0 = rw_cnt;
    run_instr(OpSw, 3'b010, 1'b0, 1'b0, 0, 3);
    check("sw_memwrite_cycles", 32'(mw_cnt - mw0), 4);
    check("sw_regwrite_cycles", 32'(rw_cnt - rw0), 0);

    pcw0 = pcw_cnt;
    run_instr(OpBeq, 3'b000, 1'b0, 1'b1, 0, 0);
    check("beq_taken_pcwrite", 32'(pcw_cnt - pcw0), 2);
    check("beq_taken_alu", 32'(exec_alu), 32'h1);
    pcw0 = pcw_cnt;
    run_instr(OpBeq, 3'b000, 1'b0, 1'b0, 0, 0);
    check("beq_not_taken_pcwrite", 32'(pcw_cnt - pcw0), 1);
    check("beq_not_taken_alu", 32'(exec_alu), 32'h1);

    pcw0 = pcw_cnt; rw0 = rw_cnt;
    run_instr(OpJal, 3'b000, 1'b0, 1'b0, 0, 0);
    check("jal_pcwrite", 32'(pcw_cnt - pcw0), 2);
    check("jal_regwrite", 32'(rw_cnt - rw0), 1);

    // addi abandoned by a reset asserted part-way through EXECI.
    op = OpI; funct3 = 3'b000; funct7b5 = 1'b0;
    step(PhFetch, 1'b1);
    step(PhDecode, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_outs", 32'(act), 32'(model(PhFetch, 1'b0)));
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_instr(OpJal, 3'b000, 1'b0, 1'b0, 0, 0);

    en0 = en_cnt;
    run_instr(OpBad, 3'b000, 1'b0, 1'b0, 0, 0);
    check("trap_enable_cycles", 32'(en_cnt - en0), 1);
    check("trap_illegal", 32'(illegal), 1);
    rst_n = 1'b0;
    #1;
    check("trap_reset_illegal", 32'(illegal), 0);
    check("trap_reset_outs", 32'(act), 32'(model(PhFetch, 1'b0)));
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_instr(OpLw, 3'b010, 1'b0, 1'b0, 1, 0);
    run_instr(OpR, 3'b000, 1'b0, 1'b0, 0, 0);
    step(PhFetch, 1'b1);

    check("length_count", 32'(lens_q.size()), 32'(exp_len_q.size()));
    for (int i = 0; i < exp_len_q.size() && i < lens_q.size(); i++) begin
      check($sformatf("instr_len%0d", i), 32'(lens_q[i]), 32'(exp_len_q[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
